graphics_pixel_writer: RTL and testbench
========================================

GRAPHICS_PIXEL_WRITER -- requirements
Module: graphics_pixel_writer

Interface
REQ-001 The module SHALL have these parameters, one per line as name, default, meaning:
- H_PIXELS, 640, frame buffer line width in pixels
- V_PIXELS, 480, frame buffer line count
- FB_BASE, 0, word address of pixel (0,0)
- FB_ADDR_WIDTH, 19, frame buffer address width
- FIFO_DEPTH, 4, input FIFO entries (power of 2)

REQ-002 The module SHALL have these ports, one per line as name, direction, width, meaning:
- clk  in  1  single clock
- clken  in  1  clock enable; all state holds when low
- reset  in  1  synchronous, active-high reset
- st_ready  out  1  Avalon-ST sink ready
- st_data  in  pixel_t  x, y, color, padding (graphics_pkg)
- st_valid  in  1  Avalon-ST sink valid
- fb_address  out  FB_ADDR_WIDTH  Avalon-MM master word address
- fb_write  out  1  Avalon-MM master write request
- fb_writedata  out  COLOR_DATA_WIDTH  pixel color
- fb_waitrequest  in  1  slave stall
- busy  out  1  pixels accepted but not yet written
- dropped_count  out  16  clipped-pixel counter

REQ-003 One clock domain (clk); reset SHALL be synchronous and active-high, named reset.

Function
REQ-004 A transfer SHALL occur on a rising clk edge with clken=1, st_valid=1 and st_ready=1.
REQ-005 Accepted pixels SHALL enter a FIFO_DEPTH-entry FIFO; st_ready = FIFO not full (registered).
REQ-006 Simultaneous push and pop on a full or empty FIFO SHALL be handled without loss or duplication; occupancy is unchanged on a simultaneous push and pop.
REQ-007 Stage A (address) SHALL pop the FIFO when A is empty or A advances in the same cycle.
- It registers address = FB_BASE + y*H_PIXELS + x, truncated to FB_ADDR_WIDTH.
- It registers color and a clip flag.
REQ-008 Clip flag SHALL be set when x >= H_PIXELS or y >= V_PIXELS.
REQ-009 A clipped entry SHALL be discarded at stage A without reaching stage B.
- dropped_count increments by 1, saturating at 16'hFFFF.
REQ-010 Stage B (master) SHALL load from stage A when B is empty or its write completes in this cycle.
- On load: fb_write=1, with fb_address and fb_writedata taken from stage A.
REQ-011 A write SHALL complete on a clken=1 edge with fb_write=1 and fb_waitrequest=0.
REQ-012 While fb_waitrequest=1, fb_address, fb_writedata and fb_write SHALL remain stable.
REQ-013 Latency SHALL be 2 cycles: a pixel accepted at edge N with an empty pipeline drives fb_write=1 after edge N+2.
REQ-014 Sustained throughput SHALL be one pixel per cycle while fb_waitrequest=0.
REQ-015 busy SHALL be high whenever the FIFO is non-empty, stage A holds an entry, or fb_write=1; otherwise low.
REQ-016 With clken=0, no transfer, FIFO change, counter change or stage advance SHALL occur; outputs hold.
REQ-017 The multiply SHALL use a constant H_PIXELS so that it synthesizes as shift-add logic; no divider.

Reset
REQ-018 On reset=1 at a clock edge, regardless of clken:
- FIFO emptied; stages A and B cleared.
- fb_write=0, fb_address=0, fb_writedata=0.
- st_ready=0 during reset, then 1 the first cycle after reset deasserts.
- busy=0; dropped_count=0.
REQ-019 Reset mid-write SHALL abandon the in-flight write and all queued pixels without emitting further writes.

Verification
REQ-020 Single pixel:
- Stimulus: pixel (x=3, y=2, color=5) with fb_waitrequest=0.
- Response: 2 cycles later, fb_write=1, fb_address=1283, fb_writedata=5 for exactly one cycle; busy then 0.
REQ-021 Stream:
- Stimulus: 7 consecutive pixels (0,1)..(6,4) with fb_waitrequest=0.
- Response: 7 writes on consecutive cycles in order; st_ready stays 1.
REQ-022 Backpressure:
- Stimulus: fb_waitrequest=1 held; pixels streamed continuously.
- Response: outputs stable; st_ready falls after FIFO_DEPTH+2 accepts.
- Stimulus: release fb_waitrequest.
- Response: all pixels are written in order, none lost.
REQ-023 Clipping:
- Stimulus: pixels (640,0), (0,480) and (639,479).
- Response: one write, to address 307199; dropped_count=2.
REQ-024 Reset mid-operation:
- Stimulus: reset asserted while fb_write=1 and the FIFO holds 3 pixels.
- Response: the next cycle shows fb_write=0, busy=0, dropped_count=0; no stale writes follow.
REQ-025 Clock enable:
- Stimulus: clken=0 for 3 cycles during the stream.
- Response: no state changes; the sequence resumes intact when clken returns to 1.

Source files
------------

// File: rtl/graphics_pixel_writer.sv
// Pixel writer: Avalon-ST pixel stream in, Avalon-MM frame buffer writes out.
// FIFO -> stage A (address/clip) -> stage B (bus master).

package graphics_pkg;
    localparam int X_WIDTH          = 12;
    localparam int Y_WIDTH          = 12;
    localparam int COLOR_DATA_WIDTH = 16;
    localparam int PAD_WIDTH        = 8;
    localparam int PIXEL_WIDTH      = X_WIDTH + Y_WIDTH + COLOR_DATA_WIDTH + PAD_WIDTH;

    typedef struct packed {
        logic [X_WIDTH-1:0]          x;
        logic [Y_WIDTH-1:0]          y;
        logic [COLOR_DATA_WIDTH-1:0] color;
        logic [PAD_WIDTH-1:0]        padding;
    } pixel_t;
endpackage

module graphics_pixel_writer
    import graphics_pkg::*;
#(
    parameter int H_PIXELS      = 640,
    parameter int V_PIXELS      = 480,
    parameter int FB_BASE       = 0,
    parameter int FB_ADDR_WIDTH = 19,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                        clk,
    input  logic                        clken,
    input  logic                        reset,
    output logic                        st_ready,
    input  logic [PIXEL_WIDTH-1:0]      st_data,
    input  logic                        st_valid,
    output logic [FB_ADDR_WIDTH-1:0]    fb_address,
    output logic                        fb_write,
    output logic [COLOR_DATA_WIDTH-1:0] fb_writedata,
    input  logic                        fb_waitrequest,
    output logic                        busy,
    output logic [15:0]                 dropped_count
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR   = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [31:0]      H_LIMIT    = H_PIXELS;
    localparam logic [31:0]      V_LIMIT    = V_PIXELS;
    localparam logic [FB_ADDR_WIDTH-1:0] BASE_ADDR = FB_ADDR_WIDTH'(FB_BASE);
    localparam logic [FB_ADDR_WIDTH-1:0] LINE_LEN  = FB_ADDR_WIDTH'(H_PIXELS);

    // Input FIFO
    pixel_t           fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W:0]   count;
    logic [PTR_W:0]   count_next;
    pixel_t           head;
    pixel_t           in_pixel;
    logic             push;
    logic             pop;

    // Stage A
    logic                        a_valid;
    logic                        a_clip;
    logic [FB_ADDR_WIDTH-1:0]    a_addr;
    logic [COLOR_DATA_WIDTH-1:0] a_color;
    logic                        a_advance;

    // Stage B handshake
    logic b_free;
    logic b_load;
    logic b_complete;

    logic [FB_ADDR_WIDTH-1:0] head_addr;
    logic                     head_clip;
    logic                     unused_pad;

    assign in_pixel   = pixel_t'(st_data);
    assign head       = fifo_mem[rd_ptr];
    assign unused_pad = ^head.padding;

    // Truncating every term to the address width keeps the result modulo 2^FB_ADDR_WIDTH;
    // LINE_LEN is constant, so the multiply reduces to shift-add logic.
    assign head_addr = BASE_ADDR
                     + FB_ADDR_WIDTH'(head.y) * LINE_LEN
                     + FB_ADDR_WIDTH'(head.x);
    assign head_clip = (32'(head.x) >= H_LIMIT) || (32'(head.y) >= V_LIMIT);

    assign b_complete = fb_write && !fb_waitrequest;
    assign b_free     = !fb_write || !fb_waitrequest;
    assign a_advance  = a_valid && (a_clip || b_free);
    assign b_load     = a_valid && !a_clip && b_free;

    assign push = clken && st_valid && st_ready;
    assign pop  = clken && (count != '0) && (!a_valid || a_advance);

    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + 1'b1;
        end else if (pop && !push) begin
            count_next = count - 1'b1;
        end
    end

    assign busy = (count != '0) || a_valid || fb_write;

    always_ff @(posedge clk) begin
        if (push && !reset) begin
            fifo_mem[wr_ptr] <= in_pixel;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            count         <= '0;
            st_ready      <= 1'b0;
            a_valid       <= 1'b0;
            a_clip        <= 1'b0;
            a_addr        <= '0;
            a_color       <= '0;
            fb_write      <= 1'b0;
            fb_address    <= '0;
            fb_writedata  <= '0;
            dropped_count <= '0;
        end else if (clken) begin
            if (push) begin
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
            end
            count    <= count_next;
            st_ready <= (count_next != FULL_COUNT);

            if (pop) begin
                a_valid <= 1'b1;
                a_clip  <= head_clip;
                a_addr  <= head_addr;
                a_color <= head.color;
            end else if (a_advance) begin
                a_valid <= 1'b0;
            end

            if (a_advance && a_clip && (dropped_count != '1)) begin
                dropped_count <= dropped_count + 1'b1;
            end

            if (b_load) begin
                fb_write     <= 1'b1;
                fb_address   <= a_addr;
                fb_writedata <= a_color;
            end else if (b_complete) begin
                fb_write <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_graphics_pixel_writer.sv
// Directed bench for graphics_pixel_writer: per-cycle vector table plus
// stream, backpressure and mid-write reset sequences.

module tb_graphics_pixel_writer;
    import graphics_pkg::*;

    logic                        clk = 1'b0;
    logic                        clken;
    logic                        reset;
    logic                        st_ready;
    logic [PIXEL_WIDTH-1:0]      st_data;
    logic                        st_valid;
    logic [18:0]                 fb_address;
    logic                        fb_write;
    logic [COLOR_DATA_WIDTH-1:0] fb_writedata;
    logic                        fb_waitrequest;
    logic                        busy;
    logic [15:0]                 dropped_count;

    int n_checks = 0;
    int n_fail   = 0;

    graphics_pixel_writer #(
        .H_PIXELS(640),
        .V_PIXELS(480),
        .FB_BASE(0),
        .FB_ADDR_WIDTH(19),
        .FIFO_DEPTH(4)
    ) dut (
        .clk(clk),
        .clken(clken),
        .reset(reset),
        .st_ready(st_ready),
        .st_data(st_data),
        .st_valid(st_valid),
        .fb_address(fb_address),
        .fb_write(fb_write),
        .fb_writedata(fb_writedata),
        .fb_waitrequest(fb_waitrequest),
        .busy(busy),
        .dropped_count(dropped_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        ce;
        logic        vld;
        int unsigned x;
        int unsigned y;
        int unsigned col;
        logic        e_write;
        int unsigned e_addr;
        int unsigned e_data;
        logic        e_ready;
        logic        e_busy;
        int unsigned e_drop;
    } vec_t;

    vec_t vecs [26];

    function automatic vec_t mk(logic rst, logic ce, logic vld, int unsigned x, int unsigned y,
                                int unsigned col, logic ew, int unsigned ea, int unsigned ed,
                                logic er, logic eb, int unsigned edrop);
        vec_t v;
        v.rst = rst; v.ce = ce; v.vld = vld; v.x = x; v.y = y; v.col = col;
        v.e_write = ew; v.e_addr = ea; v.e_data = ed;
        v.e_ready = er; v.e_busy = eb; v.e_drop = edrop;
        return v;
    endfunction

    function automatic logic [PIXEL_WIDTH-1:0] pix(int unsigned x, int unsigned y, int unsigned c);
        pixel_t p;
        p.x = 12'(x);
        p.y = 12'(y);
        p.color = 16'(c);
        p.padding = 8'h00;
        return p;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; clken = 1'b1; st_valid = 1'b0; fb_waitrequest = 1'b0;
        tick();
        reset = 1'b0;
        tick();
    endtask

    logic [31:0] exp_addr_q [$];
    logic [31:0] exp_data_q [$];

    initial begin
        clken = 1'b1; reset = 1'b1; st_valid = 1'b0; st_data = '0; fb_waitrequest = 1'b0;

        // rst ce vld x y col | write addr data ready busy dropped
        vecs[0]  = mk(1, 1, 0,   0,   0, 0, 0,      0, 0, 0, 0, 0);
        vecs[1]  = mk(0, 1, 0,   0,   0, 0, 0,      0, 0, 1, 0, 0);
        vecs[2]  = mk(0, 1, 1,   3,   2, 5, 0,      0, 0, 1, 1, 0);
        vecs[3]  = mk(0, 1, 0,   0,   0, 0, 0,      0, 0, 1, 1, 0);
        vecs[4]  = mk(0, 1, 0,   0,   0, 0, 1,   1283, 5, 1, 1, 0);
        vecs[5]  = mk(0, 1, 0,   0,   0, 0, 0,      0, 0, 1, 0, 0);
        vecs[6]  = mk(0, 1, 1, 640,   0, 1, 0,      0, 0, 1, 1, 0);
        vecs[7]  = mk(0, 1, 1,   0, 480, 2, 0,      0, 0, 1, 1, 0);
        vecs[8]  = mk(0, 1, 1, 639, 479, 9, 0,      0, 0, 1, 1, 1);
        vecs[9]  = mk(0, 1, 0,   0,   0, 0, 0,      0, 0, 1, 1, 2);
        vecs[10] = mk(0, 1, 0,   0,   0, 0, 1, 307199, 9, 1, 1, 2);
        vecs[11] = mk(0, 1, 0,   0,   0, 0, 0,      0, 0, 1, 0, 2);
        vecs[12] = mk(0, 1, 1,   1,   1, 7, 0,      0, 0, 1, 1, 2);
        vecs[13] = mk(0, 0, 1,   2,   2, 8, 0,      0, 0, 1, 1, 2);
        vecs[14] = mk(0, 0, 1,   2,   2, 8, 0,      0, 0, 1, 1, 2);
        vecs[15] = mk(0, 0, 1,   2,   2, 8, 0,      0, 0, 1, 1, 2);
        vecs[16] = mk(0, 1, 0,   0,   0, 0, 0,      0, 0, 1, 1, 2);
        vecs[17] = mk(0, 1, 0,   0,   0, 0, 1,    641, 7, 1, 1, 2);
        vecs[18] = mk(0, 0, 0,   0,   0, 0, 1,    641, 7, 1, 1, 2);
        vecs[19] = mk(0, 1, 0,   0,   0, 0, 0,      0, 0, 1, 0, 2);
        vecs[20] = mk(0, 1, 1, 900,   0, 3, 0,      0, 0, 1, 1, 2);
        vecs[21] = mk(0, 1, 0,   0,   0, 0, 0,      0, 0, 1, 1, 2);
        vecs[22] = mk(0, 0, 0,   0,   0, 0, 0,      0, 0, 1, 1, 2);
        vecs[23] = mk(0, 1, 0,   0,   0, 0, 0,      0, 0, 1, 0, 3);
        vecs[24] = mk(1, 0, 0,   0,   0, 0, 0,      0, 0, 0, 0, 0);
        vecs[25] = mk(0, 1, 0,   0,   0, 0, 0,      0, 0, 1, 0, 0);

        for (int i = 0; i < 26; i++) begin
            reset = vecs[i].rst;
            clken = vecs[i].ce;
            st_valid = vecs[i].vld;
            st_data = pix(vecs[i].x, vecs[i].y, vecs[i].col);
            fb_waitrequest = 1'b0;
            tick();
            chk($sformatf("vec%0d fb_write", i), 32'(fb_write), 32'(vecs[i].e_write));
            chk($sformatf("vec%0d st_ready", i), 32'(st_ready), 32'(vecs[i].e_ready));
            chk($sformatf("vec%0d busy", i), 32'(busy), 32'(vecs[i].e_busy));
            chk($sformatf("vec%0d dropped_count", i), 32'(dropped_count), vecs[i].e_drop);
            if (vecs[i].e_write || vecs[i].rst) begin
                chk($sformatf("vec%0d fb_address", i), 32'(fb_address), vecs[i].e_addr);
                chk($sformatf("vec%0d fb_writedata", i), 32'(fb_writedata), vecs[i].e_data);
            end
        end
        reset = 1'b0; clken = 1'b1; st_valid = 1'b0;

        // Stream of 7 pixels: writes expected on consecutive cycles after edges 2..8
        do_reset();
        for (int k = 0; k < 10; k++) begin
            int unsigned sx;
            int unsigned sy;
            st_valid = (k < 7);
            st_data = pix(k, 1 + k / 2, 16 + k);
            tick();
            if (k < 7) chk($sformatf("stream st_ready k%0d", k), 32'(st_ready), 32'd1);
            if (k >= 2 && k <= 8) begin
                sx = k - 2;
                sy = 1 + (k - 2) / 2;
                chk($sformatf("stream fb_write k%0d", k), 32'(fb_write), 32'd1);
                chk($sformatf("stream fb_address k%0d", k), 32'(fb_address), sy * 640 + sx);
                chk($sformatf("stream fb_writedata k%0d", k), 32'(fb_writedata), 16 + sx);
            end else begin
                chk($sformatf("stream idle fb_write k%0d", k), 32'(fb_write), 32'd0);
            end
        end
        st_valid = 1'b0;

        // Backpressure: waitrequest held, continuous pixel offer
        do_reset();
        begin
            int          accepts;
            int          j;
            logic        held;
            logic [31:0] held_addr;
            logic [31:0] held_data;
            int          writes;
            accepts = 0; j = 0; held = 1'b0; held_addr = '0; held_data = '0; writes = 0;
            fb_waitrequest = 1'b1;
            st_valid = 1'b1;
            st_data = pix(10, 5, 100);
            for (int c = 0; c < 12; c++) begin
                logic acc;
                acc = st_ready;
                tick();
                if (acc) begin
                    exp_addr_q.push_back(5 * 640 + 10 + j);
                    exp_data_q.push_back(100 + j);
                    accepts++;
                    j++;
                    st_data = pix(10 + j, 5, 100 + j);
                end
                if (fb_write) begin
                    if (!held) begin
                        held = 1'b1;
                        held_addr = 32'(fb_address);
                        held_data = 32'(fb_writedata);
                    end else begin
                        chk("bp stable fb_address", 32'(fb_address), held_addr);
                        chk("bp stable fb_writedata", 32'(fb_writedata), held_data);
                    end
                end else if (held) begin
                    chk("bp stable fb_write", 32'(fb_write), 32'd1);
                end
            end
            chk("bp accepts before st_ready low", 32'(accepts), 32'd6);
            chk("bp st_ready low", 32'(st_ready), 32'd0);
            chk("bp first held address", held_addr, 32'd3210);

            st_valid = 1'b0;
            fb_waitrequest = 1'b0;
            for (int c = 0; c < 30; c++) begin
                if (fb_write && !fb_waitrequest) begin
                    writes++;
                    if (exp_addr_q.size() == 0) begin
                        chk("bp unexpected write", 32'(fb_address), 32'hFFFF_FFFF);
                    end else begin
                        chk("bp drain fb_address", 32'(fb_address), exp_addr_q.pop_front());
                        chk("bp drain fb_writedata", 32'(fb_writedata), exp_data_q.pop_front());
                    end
                end
                tick();
                if (!busy && exp_addr_q.size() == 0) break;
            end
            chk("bp writes drained", 32'(writes), 32'd6);
            chk("bp pending after drain", 32'(exp_addr_q.size()), 32'd0);
            chk("bp busy after drain", 32'(busy), 32'd0);
        end

        // Reset while a write is stalled and the FIFO holds three pixels
        do_reset();
        fb_waitrequest = 1'b1;
        st_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            st_data = (k == 0) ? pix(700, 0, 1) : pix(k, 9, 50 + k);
            tick();
        end
        st_valid = 1'b0;
        chk("midreset pre fb_write", 32'(fb_write), 32'd1);
        chk("midreset pre dropped_count", 32'(dropped_count), 32'd1);
        chk("midreset pre fb_address", 32'(fb_address), 32'(9 * 640 + 1));
        reset = 1'b1;
        tick();
        chk("midreset fb_write", 32'(fb_write), 32'd0);
        chk("midreset busy", 32'(busy), 32'd0);
        chk("midreset dropped_count", 32'(dropped_count), 32'd0);
        chk("midreset st_ready", 32'(st_ready), 32'd0);
        reset = 1'b0;
        fb_waitrequest = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk($sformatf("post reset no write k%0d", k), 32'(fb_write), 32'd0);
            chk($sformatf("post reset busy k%0d", k), 32'(busy), 32'd0);
        end
        chk("post reset st_ready", 32'(st_ready), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
